// File: rtl/oled_char_feeder.sv
// Character FIFO in front of oledControl: queues bytes from the processor side
// and hands them over one at a time on the sendData/sendDataValid/sendDone handshake.
//
// state | meaning
// IDLE  | waiting for a queued byte
// LOAD  | pop head of FIFO into sendData
// SEND  | sendDataValid high, waiting for sendDone
// GAP   | one cycle with valid low between bytes
module oled_char_feeder #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [7:0]    wr_data,
  input  logic          wr_en,
  input  logic          flush,
  output logic          fifo_full,
  output logic          fifo_empty,
  output logic [AW:0]   fifo_level,
  output logic [7:0]    overflow_cnt,
  output logic          busy,
  output logic [7:0]    sendData,
  output logic          sendDataValid,
  input  logic          sendDone
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] SEND = 2'd2;
  localparam logic [1:0] GAP  = 2'd3;

  localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level;
  logic [1:0]    state;
  logic          push;
  logic          pop;

  assign fifo_level    = level;
  assign fifo_full     = (level == FULL_LEVEL);
  assign fifo_empty    = (level == '0);
  assign busy          = (state != IDLE) | ~fifo_empty;
  assign sendDataValid = (state == SEND);

  // flush discards the same-cycle write outright, so it is neither stored nor counted
  assign push = wr_en & ~fifo_full & ~flush;
  assign pop  = (state == LOAD) & ~fifo_empty;

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overflow_cnt <= 8'h00;
    end else if (wr_en && fifo_full && !flush && (overflow_cnt != 8'hFF)) begin
      overflow_cnt <= overflow_cnt + 8'h01;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      sendData <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty && !flush) begin
            state <= LOAD;
          end
        end
        LOAD: begin
          sendData <= mem[rd_ptr];
          state    <= SEND;
        end
        SEND: begin
          if (sendDone) begin
            state <= GAP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oled_char_feeder.sv
// Directed bench for oled_char_feeder: reset, single byte, string, overflow,
// flush, simultaneous push/pop, pointer wrap and reset during SEND.
module tb_oled_char_feeder;

  logic       clock;
  logic       reset_n;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       flush;
  logic       fifo_full;
  logic       fifo_empty;
  logic [4:0] fifo_level;
  logic [7:0] overflow_cnt;
  logic       busy;
  logic [7:0] sendData;
  logic       sendDataValid;
  logic       sendDone;

  int n_checks = 0;
  int n_errors = 0;

  oled_char_feeder dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .wr_data       (wr_data),
    .wr_en         (wr_en),
    .flush         (flush),
    .fifo_full     (fifo_full),
    .fifo_empty    (fifo_empty),
    .fifo_level    (fifo_level),
    .overflow_cnt  (overflow_cnt),
    .busy          (busy),
    .sendData      (sendData),
    .sendDataValid (sendDataValid),
    .sendDone      (sendDone)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_data = b;
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
  endtask

  // wait for valid, hold for delay cycles, pulse sendDone, confirm valid drops
  task automatic serve(input int delay, output logic [7:0] b);
    int n;
    n = 0;
    while (!sendDataValid && n < 200) begin
      tick();
      n++;
    end
    check_eq("serve_valid", {31'd0, sendDataValid}, 32'd1);
    b = sendData;
    repeat (delay) tick();
    check_eq("serve_hold", {24'd0, sendData}, {24'd0, b});
    sendDone = 1'b1;
    tick();
    sendDone = 1'b0;
    check_eq("gap_valid_low", {31'd0, sendDataValid}, 32'd0);
  endtask

  logic [7:0] b;
  logic [7:0] hello [5];
  int bad;

  initial begin
    hello[0] = 8'h48; hello[1] = 8'h45; hello[2] = 8'h4C; hello[3] = 8'h4C; hello[4] = 8'h4F;
    reset_n  = 1'b0;
    wr_data  = 8'h41;
    wr_en    = 1'b1;
    flush    = 1'b0;
    sendDone = 1'b0;

    // 1: writes under reset are ignored
    repeat (3) tick();
    check_eq("rst_level", {27'd0, fifo_level}, 32'd0);
    check_eq("rst_empty", {31'd0, fifo_empty}, 32'd1);
    check_eq("rst_full", {31'd0, fifo_full}, 32'd0);
    check_eq("rst_ovf", {24'd0, overflow_cnt}, 32'd0);
    check_eq("rst_data", {24'd0, sendData}, 32'd0);
    check_eq("rst_valid", {31'd0, sendDataValid}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    wr_en = 1'b0;
    reset_n = 1'b1;
    tick();

    // 2: single byte, 3-cycle latency, long sendDone delay
    wr_data = 8'h48;
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
    check_eq("single_level", {27'd0, fifo_level}, 32'd1);
    check_eq("single_busy", {31'd0, busy}, 32'd1);
    tick();
    check_eq("single_valid_n2", {31'd0, sendDataValid}, 32'd0);
    tick();
    check_eq("single_valid_n3", {31'd0, sendDataValid}, 32'd1);
    check_eq("single_data", {24'd0, sendData}, 32'h48);
    bad = 0;
    repeat (50) begin
      tick();
      if (!sendDataValid || sendData != 8'h48) bad++;
    end
    check_eq("single_hold50", bad, 32'd0);
    sendDone = 1'b1;
    tick();
    sendDone = 1'b0;
    check_eq("single_gap", {31'd0, sendDataValid}, 32'd0);
    tick();
    check_eq("single_idle_busy", {31'd0, busy}, 32'd0);

    // 3: HELLO
    for (int i = 0; i < 5; i++) write_byte(hello[i]);
    for (int i = 0; i < 5; i++) begin
      serve(3, b);
      check_eq("hello_byte", {24'd0, b}, {24'd0, hello[i]});
    end
    bad = 0;
    repeat (10) begin
      tick();
      if (sendDataValid) bad++;
    end
    check_eq("hello_extra_valid", bad, 32'd0);
    check_eq("hello_busy", {31'd0, busy}, 32'd0);

    // 4: overflow, one byte already popped into SEND
    for (int i = 0; i < 20; i++) write_byte(8'h60 + 8'(i));
    check_eq("ovf_full", {31'd0, fifo_full}, 32'd1);
    check_eq("ovf_level", {27'd0, fifo_level}, 32'd16);
    check_eq("ovf_cnt", {24'd0, overflow_cnt}, 32'd3);
    for (int i = 0; i < 17; i++) begin
      serve(1, b);
      check_eq("ovf_byte", {24'd0, b}, {24'd0, 8'h60 + 8'(i)});
    end
    tick();
    tick();
    check_eq("ovf_drained", {31'd0, busy}, 32'd0);

    // 5: flush during first SEND
    for (int i = 0; i < 8; i++) write_byte(8'h30 + 8'(i));
    check_eq("fl_level_pre", {27'd0, fifo_level}, 32'd7);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_eq("fl_level", {27'd0, fifo_level}, 32'd0);
    check_eq("fl_empty", {31'd0, fifo_empty}, 32'd1);
    check_eq("fl_valid_kept", {31'd0, sendDataValid}, 32'd1);
    check_eq("fl_ovf_kept", {24'd0, overflow_cnt}, 32'd3);
    serve(5, b);
    check_eq("fl_byte", {24'd0, b}, 32'h30);
    bad = 0;
    repeat (20) begin
      tick();
      if (sendDataValid) bad++;
    end
    check_eq("fl_no_more", bad, 32'd0);
    check_eq("fl_busy", {31'd0, busy}, 32'd0);

    // 5b: flush + write while full does not count as overflow
    for (int i = 0; i < 17; i++) write_byte(8'h10 + 8'(i));
    check_eq("flw_full", {31'd0, fifo_full}, 32'd1);
    flush   = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'hEE;
    tick();
    flush   = 1'b0;
    wr_en   = 1'b0;
    check_eq("flw_ovf", {24'd0, overflow_cnt}, 32'd3);
    check_eq("flw_level", {27'd0, fifo_level}, 32'd0);
    serve(0, b);
    check_eq("flw_byte", {24'd0, b}, 32'h10);
    tick();

    // flush in LOAD: popped byte still goes out
    write_byte(8'h77);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_eq("fload_valid", {31'd0, sendDataValid}, 32'd1);
    check_eq("fload_data", {24'd0, sendData}, 32'h77);
    serve(0, b);
    tick();

    // flush + write at idle: write discarded
    flush   = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'h99;
    tick();
    flush   = 1'b0;
    wr_en   = 1'b0;
    check_eq("fidle_level", {27'd0, fifo_level}, 32'd0);
    tick();
    tick();
    check_eq("fidle_busy", {31'd0, busy}, 32'd0);

    // 6: push in the same cycle as the LOAD pop
    write_byte(8'hA1);
    tick();
    write_byte(8'hB2);
    check_eq("sim_level", {27'd0, fifo_level}, 32'd1);
    serve(0, b);
    check_eq("sim_byte0", {24'd0, b}, 32'hA1);
    serve(0, b);
    check_eq("sim_byte1", {24'd0, b}, 32'hB2);

    // wraparound: 40 bytes in chunks of 10
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 10; j++) write_byte(8'h80 + 8'(c * 10 + j));
      for (int j = 0; j < 10; j++) begin
        serve(1, b);
        check_eq("wrap_byte", {24'd0, b}, {24'd0, 8'h80 + 8'(c * 10 + j)});
      end
    end
    tick();
    tick();
    check_eq("wrap_busy", {31'd0, busy}, 32'd0);

    // reset while in SEND drops valid immediately and loses the queue
    write_byte(8'h55);
    write_byte(8'h56);
    tick();
    check_eq("rsend_valid_pre", {31'd0, sendDataValid}, 32'd1);
    reset_n = 1'b0;
    #1;
    check_eq("rsend_valid", {31'd0, sendDataValid}, 32'd0);
    check_eq("rsend_level", {27'd0, fifo_level}, 32'd0);
    check_eq("rsend_busy", {31'd0, busy}, 32'd0);
    #3;
    reset_n = 1'b1;
    tick();
    tick();
    check_eq("rsend_after", {31'd0, sendDataValid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
